// File: rtl/prog_seq_detector.sv
// Programmable serial sequence detector with saturating match counter and a
// hex 7-segment readout of the low counter nibble (dp shows a sticky hit flag).
module prog_seq_detector #(
  parameter int unsigned MAX_LEN = 8,
  parameter int unsigned CNT_W   = 8,
  parameter int unsigned LW      = $clog2(MAX_LEN + 1)
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               ena,
  input  logic               din,
  input  logic               din_valid,
  input  logic               cfg_load,
  input  logic [MAX_LEN-1:0] pat_in,
  input  logic [LW-1:0]      len_in,
  input  logic               overlap_in,
  input  logic               cnt_clr,
  output logic               match,
  output logic [CNT_W-1:0]   match_cnt,
  output logic [7:0]         seg
);

  localparam int unsigned SEG_W = 7;

  logic [MAX_LEN-1:0] r_hist;
  logic [LW-1:0]      r_fill;
  logic [MAX_LEN-1:0] r_pat;
  logic [LW-1:0]      r_eff_len;
  logic               r_overlap;
  logic               r_match;
  logic [CNT_W-1:0]   r_match_cnt;
  logic               r_dp_flag;

  logic               w_accept;
  logic [MAX_LEN-1:0] w_hist_next;
  logic [LW-1:0]      w_fill_next;
  logic [MAX_LEN-1:0] w_mask;
  logic               w_hit;
  logic [LW-1:0]      w_len_clamped;
  logic [SEG_W-1:0]   w_font;

  assign w_accept      = ena && din_valid && !cfg_load;
  assign w_hist_next   = {r_hist[MAX_LEN-2:0], din};
  assign w_fill_next   = (r_fill == LW'(MAX_LEN)) ? r_fill : r_fill + LW'(1);
  assign w_len_clamped = (len_in > LW'(MAX_LEN)) ? LW'(MAX_LEN) : len_in;

  // Compare window covers the eff_len newest history bits
  always_comb begin
    w_mask = '0;
    for (int i = 0; i < int'(MAX_LEN); i++) begin
      w_mask[i] = (i < int'(r_eff_len));
    end
  end

  assign w_hit = w_accept && (r_eff_len != '0) && (w_fill_next >= r_eff_len) &&
                 (((w_hist_next ^ r_pat) & w_mask) == '0);

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_hist      <= '0;
      r_fill      <= '0;
      r_pat       <= '0;
      r_eff_len   <= '0;
      r_overlap   <= 1'b0;
      r_match     <= 1'b0;
      r_match_cnt <= '0;
      r_dp_flag   <= 1'b0;
    end else if (ena) begin
      if (cfg_load) begin
        r_pat     <= pat_in;
        r_eff_len <= w_len_clamped;
        r_overlap <= overlap_in;
        r_hist    <= '0;
        r_fill    <= '0;
        r_match   <= 1'b0;
      end else begin
        r_match <= w_hit;
        if (w_accept) begin
          r_hist <= w_hist_next;
          r_fill <= (w_hit && !r_overlap) ? '0 : w_fill_next;
        end
      end
      // Clear beats a coincident hit for the counter and sticky flag
      if (cnt_clr) begin
        r_match_cnt <= '0;
        r_dp_flag   <= 1'b0;
      end else if (w_hit) begin
        if (r_match_cnt != '1) r_match_cnt <= r_match_cnt + CNT_W'(1);
        r_dp_flag <= 1'b1;
      end
    end else begin
      r_match <= 1'b0;
    end
  end

  always_comb begin
    w_font = 7'h00;
    case (r_match_cnt[3:0])
      4'h0: w_font = 7'h3F;
      4'h1: w_font = 7'h06;
      4'h2: w_font = 7'h5B;
      4'h3: w_font = 7'h4F;
      4'h4: w_font = 7'h66;
      4'h5: w_font = 7'h6D;
      4'h6: w_font = 7'h7D;
      4'h7: w_font = 7'h07;
      4'h8: w_font = 7'h7F;
      4'h9: w_font = 7'h6F;
      4'hA: w_font = 7'h77;
      4'hB: w_font = 7'h7C;
      4'hC: w_font = 7'h39;
      4'hD: w_font = 7'h5E;
      4'hE: w_font = 7'h79;
      default: w_font = 7'h71;
    endcase
  end

  assign match     = r_match;
  assign match_cnt = r_match_cnt;
  assign seg       = {r_dp_flag, w_font};

endmodule

// File: tb/tb_prog_seq_detector.sv
// Scoreboard bench for prog_seq_detector: stimulus pushes expected match
// results, a negedge monitor pops and checks them whenever match pulses.
module tb_prog_seq_detector;

  localparam int unsigned MAX_LEN = 8;
  localparam int unsigned CNT_W   = 4;
  localparam int unsigned LW      = 4;

  logic               clk = 1'b0;
  logic               rst_n;
  logic               ena;
  logic               din;
  logic               din_valid;
  logic               cfg_load;
  logic [MAX_LEN-1:0] pat_in;
  logic [LW-1:0]      len_in;
  logic               overlap_in;
  logic               cnt_clr;
  logic               match;
  logic [CNT_W-1:0]   match_cnt;
  logic [7:0]         seg;

  typedef struct {
    logic [3:0] cnt;
    logic [7:0] seg;
  } exp_t;

  exp_t q[$];
  int n_cmp = 0;
  int n_err = 0;
  logic [7:0] font [16] = '{8'h3F, 8'h06, 8'h5B, 8'h4F, 8'h66, 8'h6D, 8'h7D, 8'h07,
                            8'h7F, 8'h6F, 8'h77, 8'h7C, 8'h39, 8'h5E, 8'h79, 8'h71};

  prog_seq_detector #(.MAX_LEN(MAX_LEN), .CNT_W(CNT_W), .LW(LW)) dut (
    .clk(clk), .rst_n(rst_n), .ena(ena), .din(din), .din_valid(din_valid),
    .cfg_load(cfg_load), .pat_in(pat_in), .len_in(len_in), .overlap_in(overlap_in),
    .cnt_clr(cnt_clr), .match(match), .match_cnt(match_cnt), .seg(seg)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input int act, input int exp);
    n_cmp++;
    if (act != exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Monitor: every match pulse must correspond to a queued expectation
  always @(negedge clk) begin
    if (match === 1'b1) begin
      if (q.size() == 0) begin
        n_cmp++;
        n_err++;
        $display("FAIL unexpected_match: got match=1 expected none at %0t", $time);
      end else begin
        exp_t e;
        e = q.pop_front();
        check("match_cnt", int'(match_cnt), int'(e.cnt));
        check("match_seg", int'(seg), int'(e.seg));
      end
    end
  end

  task automatic send_bit(input logic b, input logic em, input int ec, input logic [7:0] es);
    exp_t e;
    din = b;
    din_valid = 1'b1;
    if (em) begin
      e.cnt = ec[3:0];
      e.seg = es;
      q.push_back(e);
    end
    @(negedge clk);
    din_valid = 1'b0;
  endtask

  task automatic load(input logic [7:0] p, input logic [3:0] l, input logic ov);
    cfg_load = 1'b1;
    pat_in = p;
    len_in = l;
    overlap_in = ov;
    @(negedge clk);
    cfg_load = 1'b0;
  endtask

  task automatic clear();
    cnt_clr = 1'b1;
    @(negedge clk);
    cnt_clr = 1'b0;
  endtask

  // Let outstanding pulses reach the monitor, then require none pending
  task automatic drain(input string name);
    repeat (3) @(negedge clk);
    check(name, q.size(), 0);
    q.delete();
  endtask

  initial begin
    exp_t e;
    int c;
    rst_n = 1'b0; ena = 1'b0; din = 1'b0; din_valid = 1'b0; cfg_load = 1'b0;
    pat_in = '0; len_in = '0; overlap_in = 1'b0; cnt_clr = 1'b0;
    @(negedge clk);
    @(negedge clk);
    check("rst_match", int'(match), 0);
    check("rst_cnt", int'(match_cnt), 0);
    check("rst_seg", int'(seg), 'h3F);
    rst_n = 1'b1;
    ena = 1'b1;

    // Overlapping 1011 on 1011011
    load(8'h0B, 4'd4, 1'b1);
    send_bit(1, 0, 0, 0); send_bit(0, 0, 0, 0); send_bit(1, 0, 0, 0);
    send_bit(1, 1, 1, 8'h86);
    send_bit(0, 0, 0, 0); send_bit(1, 0, 0, 0);
    send_bit(1, 1, 2, 8'hDB);
    drain("ovl_pending");
    check("ovl_cnt", int'(match_cnt), 2);
    check("ovl_seg", int'(seg), 'hDB);

    // Non-overlapping on the same stream
    clear();
    load(8'h0B, 4'd4, 1'b0);
    send_bit(1, 0, 0, 0); send_bit(0, 0, 0, 0); send_bit(1, 0, 0, 0);
    send_bit(1, 1, 1, 8'h86);
    send_bit(0, 0, 0, 0); send_bit(1, 0, 0, 0); send_bit(1, 0, 0, 0);
    drain("novl_pending");
    check("novl_cnt", int'(match_cnt), 1);
    check("novl_seg", int'(seg), 'h86);

    // Zero length disables; oversize length clamps to MAX_LEN
    clear();
    load(8'hFF, 4'd0, 1'b1);
    for (int i = 0; i < 16; i++) send_bit(1, 0, 0, 0);
    drain("len0_pending");
    check("len0_cnt", int'(match_cnt), 0);
    check("len0_seg", int'(seg), 'h3F);
    load(8'hFF, 4'd12, 1'b1);
    for (int i = 1; i <= 8; i++) send_bit(1, (i == 8), 1, 8'h86);
    drain("clamp_pending");
    check("clamp_cnt", int'(match_cnt), 1);

    // Single-bit pattern saturates the 4-bit counter
    clear();
    load(8'h01, 4'd1, 1'b1);
    for (int k = 1; k <= 20; k++) begin
      c = (k > 15) ? 15 : k;
      send_bit(1, 1, c, font[c] | 8'h80);
    end
    drain("sat_pending");
    check("sat_cnt", int'(match_cnt), 15);
    check("sat_seg", int'(seg), 'hF1);
    // Clear coincident with a hit: pulse still produced, counter cleared
    cnt_clr = 1'b1;
    din = 1'b1;
    din_valid = 1'b1;
    e.cnt = 4'd0;
    e.seg = 8'h3F;
    q.push_back(e);
    @(negedge clk);
    cnt_clr = 1'b0;
    din_valid = 1'b0;
    drain("clrhit_pending");
    check("clrhit_cnt", int'(match_cnt), 0);
    check("clrhit_seg", int'(seg), 'h3F);

    // Reload mid-pattern discards the coincident bit and partial progress
    load(8'h0B, 4'd4, 1'b0);
    send_bit(1, 0, 0, 0); send_bit(0, 0, 0, 0); send_bit(1, 0, 0, 0);
    din = 1'b1;
    din_valid = 1'b1;
    load(8'h0B, 4'd4, 1'b0);
    din_valid = 1'b0;
    send_bit(1, 0, 0, 0);
    drain("reload_pending");
    check("reload_cnt", int'(match_cnt), 0);

    // Enable low freezes state while inputs churn
    load(8'h0B, 4'd4, 1'b1);
    send_bit(1, 0, 0, 0); send_bit(0, 0, 0, 0);
    ena = 1'b0;
    for (int i = 0; i < 5; i++) begin
      din = i[0];
      din_valid = 1'b1;
      cnt_clr = 1'b1;
      cfg_load = 1'b1;
      pat_in = 8'h00;
      len_in = 4'd0;
      @(negedge clk);
    end
    din_valid = 1'b0; cnt_clr = 1'b0; cfg_load = 1'b0;
    check("frozen_match", int'(match), 0);
    ena = 1'b1;
    send_bit(1, 0, 0, 0);
    send_bit(1, 1, 1, 8'h86);
    drain("ena_pending");
    check("ena_cnt", int'(match_cnt), 1);
    check("ena_seg", int'(seg), 'h86);

    // Reset mid-pattern returns outputs to reset values; detection disabled
    send_bit(1, 0, 0, 0); send_bit(0, 0, 0, 0); send_bit(1, 0, 0, 0);
    rst_n = 1'b0;
    din = 1'b1;
    din_valid = 1'b1;
    @(negedge clk);
    din_valid = 1'b0;
    check("midrst_match", int'(match), 0);
    check("midrst_cnt", int'(match_cnt), 0);
    check("midrst_seg", int'(seg), 'h3F);
    rst_n = 1'b1;
    send_bit(1, 0, 0, 0); send_bit(0, 0, 0, 0); send_bit(1, 0, 0, 0); send_bit(1, 0, 0, 0);
    drain("postrst_pending");
    check("postrst_cnt", int'(match_cnt), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/prog_seq_detector.md
PROG_SEQ_DETECTOR -- requirements
Module: prog_seq_detector

Interface
REQ-001 Parameter MAX_LEN, default 8, maximum pattern length in bits (2..16).
REQ-002 Parameter CNT_W, default 8, match-counter width (4..16).
REQ-003 Parameter LW, default $clog2(MAX_LEN+1), pattern-length port width.
REQ-004 clk  input  1  clock; all state changes on rising edge.
REQ-005 rst_n  input  1  reset, synchronous, active-low.
REQ-006 ena  input  1  global enable; low freezes all state and ignores all other inputs except rst_n.
REQ-007 din  input  1  serial data bit.
REQ-008 din_valid  input  1  din sampled this cycle when high.
REQ-009 cfg_load  input  1  latch pat_in, len_in and overlap_in.
REQ-010 pat_in  input  MAX_LEN  pattern; pat_in[len-1] is the first bit expected, pat_in[0] the last.
REQ-011 len_in  input  LW  pattern length.
REQ-012 overlap_in  input  1  1 = overlapping detection, 0 = non-overlapping.
REQ-013 cnt_clr  input  1  clear match counter and sticky flag.
REQ-014 match  output  1  one-cycle pulse per detected occurrence.
REQ-015 match_cnt  output  CNT_W  saturating count of matches.
REQ-016 seg  output  8  active-high 7-segment drive: bit0 a(top), 1 b, 2 c, 3 d, 4 e, 5 f, 6 g(middle), 7 dp.

Function
REQ-017 Bits accepted (ena && din_valid && !cfg_load) shift into history register hist: hist <= {hist[MAX_LEN-2:0], din}, so hist[0] is the newest bit.
REQ-018 fill counts accepted bits since the last reset, cfg_load or non-overlap match, and saturates at MAX_LEN.
REQ-019 Detection hit: computed on the post-shift hist and fill, and true when eff_len != 0, fill >= eff_len, and hist[eff_len-1:0] == pat[eff_len-1:0].
REQ-020 match is registered: it is high in the cycle after the edge that accepted the completing bit, for exactly one cycle, and low otherwise.
REQ-021 In overlap mode a hit does not alter hist or fill; in non-overlap mode a hit sets fill to 0 on the same edge, so the completing bit cannot start the next match.
REQ-022 eff_len is len_in clamped to MAX_LEN at load time; a stored length of 0 disables detection.
REQ-023 cfg_load (with ena high) stores pat, eff_len and overlap, and clears hist, fill and match; a din_valid in the same cycle is discarded.
REQ-024 match_cnt increments by 1 on each hit and holds at 2^CNT_W-1 (no wrap).
REQ-025 cnt_clr zeroes match_cnt and dp_flag; when a hit occurs in the same cycle, the clear wins for the counter but the match pulse is still produced.
REQ-026 dp_flag is set on any hit and holds until cnt_clr or reset.
REQ-027 seg[6:0] is a combinational hex font of match_cnt[3:0]: 0=3F 1=06 2=5B 3=4F 4=66 5=6D 6=7D 7=07 8=7F 9=6F A=77 b=7C C=39 d=5E E=79 F=71; seg[7]=dp_flag.
REQ-028 With ena low: match forced 0 next cycle, all other registers hold.

Reset
REQ-029 rst_n low at an edge, regardless of ena, sets: hist=0, fill=0, pat=0, eff_len=0 (detection disabled), overlap=0, match=0, match_cnt=0, dp_flag=0.
REQ-030 Resulting output values: seg=8'h3F.
REQ-031 Reset mid-pattern discards partial progress; a new cfg_load is required before any match.

Verification
REQ-032 MAX_LEN=8; load pat=8'h0B, len=4, overlap=1; feed 1,0,1,1,0,1,1 -> match pulses after bits 4 and 7; match_cnt=2; seg=8'hDB.
REQ-033 Same stream with overlap=0 -> single pulse after bit 4; match_cnt=1; seg=8'h86.
REQ-034 len_in=0 then 8'hFF stream of 16 ones -> no match; len_in=12 with MAX_LEN=8 and pat=8'hFF, 8 ones -> match after bit 8.
REQ-035 CNT_W=4, overlap=1, pat=1 bit "1" (len=1), 20 ones -> match_cnt saturates at 15; seg=8'hF1; cnt_clr coincident with a hit -> match=1 next cycle, match_cnt=0, seg=8'h3F.
REQ-036 Pattern 1011 loaded, feed 1,0,1 then cfg_load with din_valid=1,din=1 -> no match; the subsequent 1 does not complete a match.
REQ-037 ena low for 5 cycles mid-pattern with din toggling -> state frozen, pattern completes correctly after ena returns; rst_n low mid-pattern -> all outputs at reset values next cycle.
